// File: rtl/mcpu_mem_ltc_bram_ctl.sv
// mcpu_mem_ltc_bram_ctl
// Controller for the last-tier-cache dual-port data BRAM.
// After reset the controller writes zero to every line. It then
// round-robin arbitrates the fill engine (0) and the core write-back (1)
// onto port 0. A single reader is passed through to port 1.
// Optional feature macro: LTC_BRAM_CTL_FWD_EN. When it is defined, a
// port-1 read of a line written on port 0 in the same cycle returns the
// freshly written bytes merged over the old BRAM data.
module mcpu_mem_ltc_bram_ctl #(
    parameter int DEPTH       = 512,
    parameter int DEPTH_BITS  = 9,
    parameter int WIDTH_BYTES = 32
) (
    input  logic                            clkrst_mem_clk,
    input  logic                            clkrst_mem_rst,
    input  logic [1:0]                      rq_valid,
    output logic [1:0]                      rq_ready,
    input  logic [2*DEPTH_BITS-1:0]         rq_addr,
    input  logic [2*WIDTH_BYTES-1:0]        rq_wbe,
    input  logic [2*WIDTH_BYTES*8-1:0]      rq_wdata,
    input  logic [1:0]                      rq_re,
    output logic                            rd0_valid,
    output logic                            rd0_id,
    output logic [WIDTH_BYTES*8-1:0]        rd0_data,
    input  logic                            p1_valid,
    output logic                            p1_ready,
    input  logic [DEPTH_BITS-1:0]           p1_addr,
    output logic                            p1_rvalid,
    output logic [WIDTH_BYTES*8-1:0]        p1_rdata,
    output logic                            init_done,
    output logic [DEPTH_BITS-1:0]           bram_addr0,
    output logic [DEPTH_BITS-1:0]           bram_addr1,
    output logic [WIDTH_BYTES-1:0]          bram_wbe0,
    output logic [WIDTH_BYTES*8-1:0]        bram_wdata0,
    output logic                            bram_re0,
    output logic                            bram_re1,
    input  logic [WIDTH_BYTES*8-1:0]        bram_rdata0,
    input  logic [WIDTH_BYTES*8-1:0]        bram_rdata1
);

    localparam int LINE_W = WIDTH_BYTES * 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [DEPTH_BITS-1:0]   init_cnt;
    logic                    last_gnt;
    logic [1:0]              gnt;
    logic                    sel;
    logic [DEPTH_BITS-1:0]   addr_sel;
    logic [WIDTH_BYTES-1:0]  wbe_sel;
    logic [LINE_W-1:0]       wdata_sel;
    logic                    re_sel;
    logic                    rd0_vld_p1;
    logic                    rd0_id_p1;
    logic                    p1_vld_p1;

    // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] vld, input logic last);
        logic [1:0] pick;
        pick = 2'b00;
        case (vld)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
        return pick;
    endfunction

    assign init_done = (state == ST_RUN);
    assign gnt       = init_done ? rr_pick(rq_valid, last_gnt) : 2'b00;
    assign sel       = gnt[1];
    assign addr_sel  = sel ? rq_addr[DEPTH_BITS +: DEPTH_BITS]  : rq_addr[0 +: DEPTH_BITS];
    assign wbe_sel   = sel ? rq_wbe[WIDTH_BYTES +: WIDTH_BYTES] : rq_wbe[0 +: WIDTH_BYTES];
    assign wdata_sel = sel ? rq_wdata[LINE_W +: LINE_W]         : rq_wdata[0 +: LINE_W];
    assign re_sel    = sel ? rq_re[1] : rq_re[0];

    // State register: INIT sweep after every reset, then RUN until the next reset.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and port-0 drive: sweep zeros during INIT, granted requester during RUN.
    always_comb begin
        state_nxt   = state;
        rq_ready    = 2'b00;
        bram_addr0  = init_cnt;
        bram_wbe0   = '0;
        bram_wdata0 = '0;
        bram_re0    = 1'b0;
        case (state)
            ST_INIT: begin
                bram_wbe0 = '1;
                if (init_cnt == DEPTH_BITS'(DEPTH - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                rq_ready = gnt;
                if (|gnt) begin
                    bram_addr0  = addr_sel;
                    bram_wbe0   = wbe_sel;
                    bram_wdata0 = wdata_sel;
                    bram_re0    = re_sel;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Sweep line counter: advances once per INIT cycle, restarts from 0 on reset.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Last-grant pointer: moves only when a transfer is accepted.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            last_gnt <= 1'b1;
        end else if (|gnt) begin
            last_gnt <= sel;
        end
    end

    // Read-return tags: valid and owner follow the BRAM's one-cycle read latency.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            rd0_vld_p1 <= 1'b0;
            rd0_id_p1  <= 1'b0;
            p1_vld_p1  <= 1'b0;
        end else begin
            rd0_vld_p1 <= bram_re0;
            p1_vld_p1  <= bram_re1;
            if (bram_re0) begin
                rd0_id_p1 <= sel;
            end
        end
    end

    assign rd0_valid  = rd0_vld_p1;
    assign rd0_id     = rd0_id_p1;
    assign rd0_data   = bram_rdata0;
    assign p1_ready   = init_done;
    assign p1_rvalid  = p1_vld_p1;
    assign bram_addr1 = p1_addr;
    assign bram_re1   = p1_valid & init_done;

`ifdef LTC_BRAM_CTL_FWD_EN
    logic                    fwd_hit_p0;
    logic                    fwd_hit_p1;
    logic [WIDTH_BYTES-1:0]  fwd_wbe_p1;
    logic [LINE_W-1:0]       fwd_wdata_p1;

    // Byte merge: written bytes replace the stale BRAM bytes.
    function automatic logic [LINE_W-1:0] fwd_merge(input logic [WIDTH_BYTES-1:0] wbe,
                                                    input logic [LINE_W-1:0]      wd,
                                                    input logic [LINE_W-1:0]      rd);
        logic [LINE_W-1:0] m;
        m = rd;
        for (int b = 0; b < WIDTH_BYTES; b++) begin
            if (wbe[b]) begin
                m[b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        return m;
    endfunction

    assign fwd_hit_p0 = bram_re1 & (|gnt) & (|bram_wbe0) & (bram_addr1 == bram_addr0);

    // Forward-hit flag: control, cleared on reset so no stale merge survives.
    always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
        if (clkrst_mem_rst) begin
            fwd_hit_p1 <= 1'b0;
        end else begin
            fwd_hit_p1 <= fwd_hit_p0;
        end
    end

    // Forward data capture: only consulted when the hit flag is set.
    always_ff @(posedge clkrst_mem_clk) begin
        fwd_wbe_p1   <= bram_wbe0;
        fwd_wdata_p1 <= bram_wdata0;
    end

    assign p1_rdata = fwd_hit_p1 ? fwd_merge(fwd_wbe_p1, fwd_wdata_p1, bram_rdata1) : bram_rdata1;
`else
    assign p1_rdata = bram_rdata1;
`endif

endmodule

// File: tb/tb_mcpu_mem_ltc_bram_ctl.sv
// tb_mcpu_mem_ltc_bram_ctl
// Directed bench for the LTC BRAM controller with a behavioural dual-port
// BRAM (registered reads, read-first on port 0, old data on port 1).
module tb_mcpu_mem_ltc_bram_ctl;

    localparam int DEPTH       = 512;
    localparam int DEPTH_BITS  = 9;
    localparam int WIDTH_BYTES = 32;
    localparam int LINE_W      = WIDTH_BYTES * 8;

    logic                        clkrst_mem_clk = 1'b0;
    logic                        clkrst_mem_rst;
    logic [1:0]                  rq_valid;
    logic [1:0]                  rq_ready;
    logic [DEPTH_BITS-1:0]       a0, a1;
    logic [WIDTH_BYTES-1:0]      wbe0_i, wbe1_i;
    logic [LINE_W-1:0]           wd0_i, wd1_i;
    logic [1:0]                  rq_re;
    logic                        rd0_valid;
    logic                        rd0_id;
    logic [LINE_W-1:0]           rd0_data;
    logic                        p1_valid;
    logic                        p1_ready;
    logic [DEPTH_BITS-1:0]       p1_addr;
    logic                        p1_rvalid;
    logic [LINE_W-1:0]           p1_rdata;
    logic                        init_done;
    logic [DEPTH_BITS-1:0]       bram_addr0, bram_addr1;
    logic [WIDTH_BYTES-1:0]      bram_wbe0;
    logic [LINE_W-1:0]           bram_wdata0;
    logic                        bram_re0, bram_re1;
    logic [LINE_W-1:0]           bram_rdata0, bram_rdata1;

    logic [LINE_W-1:0]           mem [DEPTH];
    logic [LINE_W-1:0]           wmerge;

    int checks = 0;
    int errors = 0;

    always #5 clkrst_mem_clk = ~clkrst_mem_clk;

    mcpu_mem_ltc_bram_ctl #(
        .DEPTH       (DEPTH),
        .DEPTH_BITS  (DEPTH_BITS),
        .WIDTH_BYTES (WIDTH_BYTES)
    ) dut (
        .clkrst_mem_clk (clkrst_mem_clk),
        .clkrst_mem_rst (clkrst_mem_rst),
        .rq_valid       (rq_valid),
        .rq_ready       (rq_ready),
        .rq_addr        ({a1, a0}),
        .rq_wbe         ({wbe1_i, wbe0_i}),
        .rq_wdata       ({wd1_i, wd0_i}),
        .rq_re          (rq_re),
        .rd0_valid      (rd0_valid),
        .rd0_id         (rd0_id),
        .rd0_data       (rd0_data),
        .p1_valid       (p1_valid),
        .p1_ready       (p1_ready),
        .p1_addr        (p1_addr),
        .p1_rvalid      (p1_rvalid),
        .p1_rdata       (p1_rdata),
        .init_done      (init_done),
        .bram_addr0     (bram_addr0),
        .bram_addr1     (bram_addr1),
        .bram_wbe0      (bram_wbe0),
        .bram_wdata0    (bram_wdata0),
        .bram_re0       (bram_re0),
        .bram_re1       (bram_re1),
        .bram_rdata0    (bram_rdata0),
        .bram_rdata1    (bram_rdata1)
    );

    // Behavioural BRAM: byte-masked write merge for port 0.
    always_comb begin
        wmerge = mem[bram_addr0];
        for (int b = 0; b < WIDTH_BYTES; b++) begin
            if (bram_wbe0[b]) wmerge[b*8 +: 8] = bram_wdata0[b*8 +: 8];
        end
    end

    // Behavioural BRAM: registered reads see pre-write contents on both ports.
    always_ff @(posedge clkrst_mem_clk) begin
        if (bram_re0)   bram_rdata0      <= mem[bram_addr0];
        if (bram_re1)   bram_rdata1      <= mem[bram_addr1];
        if (|bram_wbe0) mem[bram_addr0]  <= wmerge;
    end

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkrst_mem_clk);
        #1;
    endtask

    // Walk the sweep, counting cycles and any cycle whose port-0/handshake drive is wrong.
    task automatic run_init(input int limit, output int cyc, output int bad);
        cyc = 0;
        bad = 0;
        while (!init_done && cyc < limit) begin
            if (bram_addr0 !== cyc[DEPTH_BITS-1:0] || bram_wbe0 !== '1 || bram_wdata0 !== '0 ||
                bram_re0 !== 1'b0 || bram_re1 !== 1'b0 || rq_ready !== 2'b00 ||
                p1_ready !== 1'b0 || p1_rvalid !== 1'b0 || rd0_valid !== 1'b0)
                bad++;
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int bad;
        logic [LINE_W-1:0] exp_fwd;

        clkrst_mem_rst = 1'b1;
        rq_valid = 2'b11;
        rq_re    = 2'b11;
        a0 = 9'd0;  a1 = 9'd1;
        wbe0_i = '0; wbe1_i = '0;
        wd0_i  = '0; wd1_i  = '0;
        p1_valid = 1'b1;
        p1_addr  = 9'd3;
        repeat (3) tick();

        // Reset state with requests and a port-1 read already pending
        chk("rst_rq_ready",  rq_ready,   2'b00);
        chk("rst_p1_ready",  p1_ready,   1'b0);
        chk("rst_init_done", init_done,  1'b0);
        chk("rst_rd0_valid", rd0_valid,  1'b0);
        chk("rst_p1_rvalid", p1_rvalid,  1'b0);
        chk("rst_re1",       bram_re1,   1'b0);
        chk("rst_wbe0",      bram_wbe0,  {WIDTH_BYTES{1'b1}});
        chk("rst_addr0",     bram_addr0, 9'd0);

        // Sweep interrupted at line 100 by a reset pulse
        clkrst_mem_rst = 1'b0;
        run_init(100, cyc, bad);
        chk("abort_cycles", cyc, 100);
        chk("abort_bad",    bad, 0);
        chk("abort_addr",   bram_addr0, 9'd100);
        clkrst_mem_rst = 1'b1;
        #1;
        chk("abort_rst_addr0", bram_addr0, 9'd0);
        chk("abort_rst_done",  init_done,  1'b0);
        tick();
        clkrst_mem_rst = 1'b0;

        // Full sweep from line 0
        run_init(600, cyc, bad);
        chk("init_cycles", cyc, DEPTH);
        chk("init_bad",    bad, 0);
        chk("init_done",   init_done, 1'b1);
        chk("p1_ready",    p1_ready,  1'b1);
        p1_valid = 1'b0;
        #1;

        // Continuous contention: grants 0,1,0,1 with tags one cycle behind
        for (int i = 0; i < 4; i++) begin
            chk("tie_grant", rq_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("tie_rd0_valid", rd0_valid, 1'b1);
            chk("tie_rd0_id",    rd0_id,    (i % 2 == 0) ? 1'b0 : 1'b1);
            chk("tie_rd0_data",  rd0_data,  '0);
        end

        // Requester 1 writes 0xAA.. to line 5
        rq_valid = 2'b10; rq_re = 2'b00;
        a1 = 9'd5; wbe1_i = '1; wd1_i = {WIDTH_BYTES{8'hAA}};
        #1;
        chk("wb_grant", rq_ready, 2'b10);
        tick();
        chk("wb_no_rvalid", rd0_valid, 1'b0);

        // Requester 0 reads line 5 next cycle
        rq_valid = 2'b01; rq_re = 2'b01; a0 = 9'd5; wbe1_i = '0;
        #1;
        chk("rd5_grant", rq_ready, 2'b01);
        tick();
        chk("rd5_valid", rd0_valid, 1'b1);
        chk("rd5_id",    rd0_id,    1'b0);
        chk("rd5_data",  rd0_data,  {WIDTH_BYTES{8'hAA}});

        // Read-first: write 0x55.. and read line 5 in one request
        rq_valid = 2'b10; rq_re = 2'b10; wbe1_i = '1; wd1_i = {WIDTH_BYTES{8'h55}};
        #1;
        tick();
        chk("rf_id",   rd0_id,   1'b1);
        chk("rf_data", rd0_data, {WIDTH_BYTES{8'hAA}});
        rq_valid = 2'b01; rq_re = 2'b01; wbe1_i = '0;
        #1;
        tick();
        chk("rf_after", rd0_data, {WIDTH_BYTES{8'h55}});

        // No request: port 0 idle
        rq_valid = 2'b00; rq_re = 2'b00;
        #1;
        chk("idle_ready", rq_ready,  2'b00);
        chk("idle_wbe0",  bram_wbe0, '0);
        chk("idle_re0",   bram_re0,  1'b0);

        // Same-cycle write of byte 0 = 0x5A to line 7 and a port-1 read of line 7
        rq_valid = 2'b01; a0 = 9'd7; wbe0_i = 32'h1; wd0_i = '0; wd0_i[7:0] = 8'h5A;
        p1_valid = 1'b1; p1_addr = 9'd7;
        #1;
        chk("fwd_re1", bram_re1, 1'b1);
        tick();
`ifdef LTC_BRAM_CTL_FWD_EN
        exp_fwd = {{(LINE_W-8){1'b0}}, 8'h5A};
`else
        exp_fwd = '0;
`endif
        chk("fwd_rvalid", p1_rvalid, 1'b1);
        chk("fwd_rdata",  p1_rdata,  exp_fwd);
        rq_valid = 2'b00; wbe0_i = '0;
        #1;
        tick();
        chk("p1_after_data", p1_rdata, {{(LINE_W-8){1'b0}}, 8'h5A});
        p1_valid = 1'b0;
        #1;
        tick();
        chk("p1_idle_rvalid", p1_rvalid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
